// File: rtl/param_fifo_if.sv
// Handshake and status bundle for param_fifo.
// The master side drives requests and the slave side (the FIFO) returns data and flags.
interface param_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr;
    logic [DATA_W-1:0] din;
    logic              rd;
    logic              clr_err;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, din, rd, clr_err,
        input  dout, full, empty, almost_full, almost_empty, fifo_cnt, overflow, underflow
    );

    modport slave (
        input  wr, din, rd, clr_err,
        output dout, full, empty, almost_full, almost_empty, fifo_cnt, overflow, underflow
    );
endinterface

// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with occupancy-decoded flags, sticky error flags
// and an optional first-word-fall-through read port.
module param_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input logic       clk,
    input logic       rst,
    param_fifo_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dout_q;
    logic              ovf_q;
    logic              udf_q;
    logic              rd_ok;
    logic              wr_ok;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        rd_ok = bus.rd && (cnt != '0);
        wr_ok = bus.wr && ((cnt != CNT_W'(DEPTH)) || rd_ok);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout_q <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            ovf_q <= (bus.wr && !wr_ok) || (ovf_q && !bus.clr_err);
            udf_q <= (bus.rd && !rd_ok) || (udf_q && !bus.clr_err);
        end
    end

    // In FWFT mode dout_q tracks the last word popped, so it is exactly the value to hold while empty.
    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout = (cnt != '0) ? mem[rd_ptr] : dout_q;
        end else begin : g_std
            assign bus.dout = dout_q;
        end
    endgenerate

    assign bus.fifo_cnt     = cnt;
    assign bus.empty        = (cnt == '0);
    assign bus.full         = (cnt == CNT_W'(DEPTH));
    assign bus.almost_full  = (cnt >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (cnt <= CNT_W'(AE_LEVEL));
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_param_fifo.sv
// Directed scoreboard bench for param_fifo: default standard mode, a 16x32 instance
// and a first-word-fall-through instance, all sharing one clock and reset.
module tb_param_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_fifo_if #(.DATA_W(8),  .DEPTH(8))  ia ();
    param_fifo_if #(.DATA_W(32), .DEPTH(16)) ib ();
    param_fifo_if #(.DATA_W(8),  .DEPTH(8))  ic ();

    param_fifo #(.DATA_W(8), .DEPTH(8)) ua (.clk(clk), .rst(rst), .bus(ia));
    param_fifo #(.DATA_W(32), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(4)) ub (.clk(clk), .rst(rst), .bus(ib));
    param_fifo #(.DATA_W(8), .DEPTH(8), .FWFT(1)) uc (.clk(clk), .rst(rst), .bus(ic));

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, one slot per instance (0 = ua, 1 = ub, 2 = uc).
    int          mcnt  [3];
    logic        mov   [3];
    logic        mud   [3];
    logic [31:0] mlast [3];
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] qc [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic q_push(input int k, input logic [31:0] d);
        case (k)
            0:       qa.push_back(d);
            1:       qb.push_back(d);
            default: qc.push_back(d);
        endcase
    endtask

    function automatic logic [31:0] q_pop(input int k);
        case (k)
            0:       return qa.pop_front();
            1:       return qb.pop_front();
            default: return qc.pop_front();
        endcase
    endfunction

    function automatic logic [31:0] q_front(input int k);
        case (k)
            0:       return qa[0];
            1:       return qb[0];
            default: return qc[0];
        endcase
    endfunction

    task automatic model_step(input int k, input int depth, input logic w, input logic r,
                              input logic c, input logic [31:0] d);
        logic rok;
        logic wok;
        rok = r && (mcnt[k] != 0);
        wok = w && ((mcnt[k] != depth) || rok);
        if (wok) q_push(k, d);
        if (rok) mlast[k] = q_pop(k);
        if (wok && !rok) mcnt[k]++;
        else if (rok && !wok) mcnt[k]--;
        mov[k] = (w && !wok) || (mov[k] && !c);
        mud[k] = (r && !rok) || (mud[k] && !c);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; mov[k] = 1'b0; mud[k] = 1'b0; mlast[k] = '0;
        end
        qa.delete(); qb.delete(); qc.delete();
    endtask

    task automatic chk_a(input string tag);
        check({tag, ".dout"},  32'(ia.dout), mlast[0]);
        check({tag, ".cnt"},   32'(ia.fifo_cnt), 32'(mcnt[0]));
        check({tag, ".empty"}, 32'(ia.empty), 32'(mcnt[0] == 0));
        check({tag, ".full"},  32'(ia.full), 32'(mcnt[0] == 8));
        check({tag, ".af"},    32'(ia.almost_full), 32'(mcnt[0] >= 6));
        check({tag, ".ae"},    32'(ia.almost_empty), 32'(mcnt[0] <= 2));
        check({tag, ".ovf"},   32'(ia.overflow), 32'(mov[0]));
        check({tag, ".udf"},   32'(ia.underflow), 32'(mud[0]));
    endtask

    task automatic chk_b(input string tag);
        check({tag, ".dout"},  ib.dout, mlast[1]);
        check({tag, ".cnt"},   32'(ib.fifo_cnt), 32'(mcnt[1]));
        check({tag, ".empty"}, 32'(ib.empty), 32'(mcnt[1] == 0));
        check({tag, ".full"},  32'(ib.full), 32'(mcnt[1] == 16));
        check({tag, ".af"},    32'(ib.almost_full), 32'(mcnt[1] >= 14));
        check({tag, ".ae"},    32'(ib.almost_empty), 32'(mcnt[1] <= 4));
        check({tag, ".ovf"},   32'(ib.overflow), 32'(mov[1]));
        check({tag, ".udf"},   32'(ib.underflow), 32'(mud[1]));
    endtask

    task automatic chk_c(input string tag);
        logic [31:0] exp_dout;
        exp_dout = (mcnt[2] != 0) ? q_front(2) : mlast[2];
        check({tag, ".dout"},  32'(ic.dout), exp_dout);
        check({tag, ".cnt"},   32'(ic.fifo_cnt), 32'(mcnt[2]));
        check({tag, ".empty"}, 32'(ic.empty), 32'(mcnt[2] == 0));
        check({tag, ".full"},  32'(ic.full), 32'(mcnt[2] == 8));
        check({tag, ".ovf"},   32'(ic.overflow), 32'(mov[2]));
        check({tag, ".udf"},   32'(ic.underflow), 32'(mud[2]));
    endtask

    task automatic cyc_a(input logic w, input logic r, input logic [7:0] d, input logic c, input string tag);
        ia.wr = w; ia.rd = r; ia.din = d; ia.clr_err = c;
        @(posedge clk); #1;
        model_step(0, 8, w, r, c, 32'(d));
        chk_a(tag);
        ia.wr = 1'b0; ia.rd = 1'b0; ia.din = '0; ia.clr_err = 1'b0;
    endtask

    task automatic cyc_b(input logic w, input logic r, input logic [31:0] d, input logic c, input string tag);
        ib.wr = w; ib.rd = r; ib.din = d; ib.clr_err = c;
        @(posedge clk); #1;
        model_step(1, 16, w, r, c, d);
        chk_b(tag);
        ib.wr = 1'b0; ib.rd = 1'b0; ib.din = '0; ib.clr_err = 1'b0;
    endtask

    task automatic cyc_c(input logic w, input logic r, input logic [7:0] d, input logic c, input string tag);
        ic.wr = w; ic.rd = r; ic.din = d; ic.clr_err = c;
        @(posedge clk); #1;
        model_step(2, 8, w, r, c, 32'(d));
        chk_c(tag);
        ic.wr = 1'b0; ic.rd = 1'b0; ic.din = '0; ic.clr_err = 1'b0;
    endtask

    initial begin
        ia.wr = 1'b0; ia.rd = 1'b0; ia.din = '0; ia.clr_err = 1'b0;
        ib.wr = 1'b0; ib.rd = 1'b0; ib.din = '0; ib.clr_err = 1'b0;
        ic.wr = 1'b0; ic.rd = 1'b0; ic.din = '0; ic.clr_err = 1'b0;
        model_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk_a("a_reset"); chk_b("b_reset"); chk_c("c_reset");
        rst = 1'b0;

        // Fill and drain the default instance.
        for (int i = 1; i <= 8; i++) cyc_a(1'b1, 1'b0, 8'(i), 1'b0, "a_fill");
        for (int i = 0; i < 8; i++)  cyc_a(1'b0, 1'b1, 8'h00, 1'b0, "a_drain");

        // Simultaneous read/write while full, then overflow and clear.
        for (int i = 0; i < 8; i++) cyc_a(1'b1, 1'b0, 8'(8'h11 + i), 1'b0, "a_refill");
        cyc_a(1'b1, 1'b1, 8'hAA, 1'b0, "a_full_rw");
        cyc_a(1'b1, 1'b0, 8'h55, 1'b0, "a_ovf");
        cyc_a(1'b0, 1'b0, 8'h00, 1'b1, "a_clr_ovf");
        for (int i = 0; i < 8; i++) cyc_a(1'b0, 1'b1, 8'h00, 1'b0, "a_drain2");

        // Underflow, set-beats-clear, and rd+wr on empty.
        cyc_a(1'b0, 1'b1, 8'h00, 1'b0, "a_udf");
        cyc_a(1'b0, 1'b1, 8'h00, 1'b1, "a_udf_setwins");
        cyc_a(1'b0, 1'b0, 8'h00, 1'b1, "a_clr_udf");
        cyc_a(1'b1, 1'b1, 8'h33, 1'b0, "a_empty_rw");
        cyc_a(1'b0, 1'b1, 8'h00, 1'b1, "a_rd33");

        // Pointer wrap with single occupancy.
        for (int i = 0; i < 20; i++) begin
            cyc_a(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, "a_wrap_w");
            cyc_a(1'b0, 1'b1, 8'h00, 1'b0, "a_wrap_r");
        end

        // Wide, deep instance: wrap, fill to full, overflow, drain.
        for (int i = 0; i < 20; i++) begin
            cyc_b(1'b1, 1'b0, $urandom(), 1'b0, "b_wrap_w");
            cyc_b(1'b0, 1'b1, 32'h0, 1'b0, "b_wrap_r");
        end
        for (int i = 0; i < 16; i++) cyc_b(1'b1, 1'b0, $urandom(), 1'b0, "b_fill");
        cyc_b(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, "b_ovf");
        for (int i = 0; i < 16; i++) cyc_b(1'b0, 1'b1, 32'h0, 1'b0, "b_drain");

        // First-word-fall-through instance.
        cyc_c(1'b1, 1'b0, 8'h5A, 1'b0, "c_ffwt_first");
        cyc_c(1'b0, 1'b1, 8'h00, 1'b0, "c_ack_empty");
        cyc_c(1'b0, 1'b0, 8'h00, 1'b0, "c_hold");
        cyc_c(1'b1, 1'b0, 8'hC1, 1'b0, "c_w1");
        cyc_c(1'b1, 1'b0, 8'hC2, 1'b0, "c_w2");
        cyc_c(1'b1, 1'b1, 8'hC3, 1'b0, "c_rw");
        cyc_c(1'b0, 1'b1, 8'h00, 1'b0, "c_r1");
        cyc_c(1'b0, 1'b1, 8'h00, 1'b0, "c_r2");
        cyc_c(1'b0, 1'b1, 8'h00, 1'b0, "c_udf");

        // Asynchronous reset between clock edges with words stored.
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 1'b0, 8'(8'h90 + i), 1'b0, "a_pre_rst");
        cyc_a(1'b0, 1'b1, 8'h00, 1'b0, "a_pre_rst_rd");
        cyc_a(1'b1, 1'b0, 8'h95, 1'b0, "a_pre_rst_w");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_a("a_async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        cyc_a(1'b1, 1'b0, 8'h77, 1'b0, "a_post_w");
        cyc_a(1'b0, 1'b1, 8'h00, 1'b0, "a_post_r");
        cyc_a(1'b0, 1'b1, 8'h00, 1'b0, "a_post_udf");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
